// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Recovers hex digits from a multiplexed 4-digit seven-segment
//               bus and publishes a 16-bit frame once every digit is captured.
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] hex_value,
  output logic        frame_valid,
  output logic [3:0]  digit_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_STABLE  = CNT_W'(STABLE_CYCLES);
  localparam bit               C_IMMEDIATE = (STABLE_CYCLES <= 1);

  // Input registers
  logic [6:0]       r_seg_q;
  logic [3:0]       r_an_q;

  // Tracker state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ref_an;
  logic [6:0]       r_ref_seg;

  // Frame assembly
  logic [15:0]      r_stage;
  logic [3:0]       r_err_stage;
  logic [3:0]       r_mask;
  logic [15:0]      r_hex_value;
  logic             r_frame_valid;
  logic [3:0]       r_digit_err;

  logic             w_an_legal;
  logic             w_same;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [1:0]       w_ref_idx;
  logic [3:0]       w_ref_bit;
  logic [3:0]       w_ref_nib;
  logic             w_ref_ok;
  logic             w_do_capture;
  logic             w_mask_full;
  logic [3:0]       w_mask_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q <= 7'h7F;
      r_an_q  <= 4'hF;
    end else begin
      r_seg_q <= seg_n;
      r_an_q  <= an_n;
    end
  end

  always_comb begin
    w_an_legal = 1'b0;
    case (r_an_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_an_legal = 1'b1;
      default:                            w_an_legal = 1'b0;
    endcase
  end

  assign w_same    = (r_an_q == r_ref_an) && (r_seg_q == r_ref_seg);
  assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

  // The reference anode is always legal once captured, so it maps to one index.
  always_comb begin
    w_ref_idx = 2'd0;
    case (r_ref_an)
      4'b1110: w_ref_idx = 2'd0;
      4'b1101: w_ref_idx = 2'd1;
      4'b1011: w_ref_idx = 2'd2;
      4'b0111: w_ref_idx = 2'd3;
      default: w_ref_idx = 2'd0;
    endcase
  end

  assign w_ref_bit = 4'b0001 << w_ref_idx;

  always_comb begin
    w_ref_nib = 4'h0;
    w_ref_ok  = 1'b1;
    case (r_ref_seg)
      7'h40: w_ref_nib = 4'h0;
      7'h79: w_ref_nib = 4'h1;
      7'h24: w_ref_nib = 4'h2;
      7'h30: w_ref_nib = 4'h3;
      7'h19: w_ref_nib = 4'h4;
      7'h12: w_ref_nib = 4'h5;
      7'h02: w_ref_nib = 4'h6;
      7'h78: w_ref_nib = 4'h7;
      7'h00: w_ref_nib = 4'h8;
      7'h10: w_ref_nib = 4'h9;
      7'h08: w_ref_nib = 4'hA;
      7'h03: w_ref_nib = 4'hB;
      7'h46: w_ref_nib = 4'hC;
      7'h21: w_ref_nib = 4'hD;
      7'h06: w_ref_nib = 4'hE;
      7'h0E: w_ref_nib = 4'hF;
      default: begin
        w_ref_nib = 4'h0;
        w_ref_ok  = 1'b0;
      end
    endcase
  end

  // Digit tracker: a new legal reference always restarts stability counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ref_an  <= 4'hF;
      r_ref_seg <= 7'h7F;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_an_legal) begin
            r_ref_an  <= r_an_q;
            r_ref_seg <= r_seg_q;
            r_cnt     <= C_CNT_ONE;
            r_state   <= C_IMMEDIATE ? S_CAPTURE : S_TRACK;
          end else begin
            r_cnt <= '0;
          end
        end
        S_TRACK: begin
          if (w_same) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= C_STABLE) begin
              r_state <= S_CAPTURE;
            end
          end else if (w_an_legal) begin
            r_ref_an  <= r_an_q;
            r_ref_seg <= r_seg_q;
            r_cnt     <= C_CNT_ONE;
            r_state   <= C_IMMEDIATE ? S_CAPTURE : S_TRACK;
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (w_an_legal) begin
            r_state <= S_HOLD;
          end else begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!w_same) begin
            if (w_an_legal) begin
              r_ref_an  <= r_an_q;
              r_ref_seg <= r_seg_q;
              r_cnt     <= C_CNT_ONE;
              r_state   <= C_IMMEDIATE ? S_CAPTURE : S_TRACK;
            end else begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_do_capture = (r_state == S_CAPTURE);
  assign w_mask_full  = &r_mask;
  assign w_mask_base  = w_mask_full ? 4'b0000 : r_mask;

  // Publishing reads the stage before any same-cycle capture writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage       <= '0;
      r_err_stage   <= '0;
      r_mask        <= '0;
      r_hex_value   <= '0;
      r_frame_valid <= 1'b0;
      r_digit_err   <= '0;
    end else begin
      r_frame_valid <= w_mask_full;
      if (w_mask_full) begin
        r_hex_value <= r_stage;
        r_digit_err <= r_err_stage;
      end
      r_mask <= w_mask_base | (w_do_capture ? w_ref_bit : 4'b0000);
      if (w_do_capture) begin
        if (w_ref_ok) begin
          r_stage[w_ref_idx*4 +: 4] <= w_ref_nib;
          r_err_stage[w_ref_idx]    <= 1'b0;
        end else begin
          r_err_stage[w_ref_idx]    <= 1'b1;
        end
      end
    end
  end

  assign hex_value   = r_hex_value;
  assign frame_valid = r_frame_valid;
  assign digit_err   = r_digit_err;

endmodule
`default_nettype wire
